// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory path.
// Imported by the responder, its bus interface and the storage array.
package mips_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus: request from the pipeline, response and stall back.
interface dmem_responder_if;
  import mips_pkg::*;

  logic              memreadM;
  logic              memwriteM;
  logic [ADDR_W-1:0] aluoutM;
  logic [DATA_W-1:0] writedataM;
  logic [DATA_W-1:0] readdataM;
  logic              memstallM;
  logic              misalignM;

  modport master (
    output memreadM, memwriteM, aluoutM, writedataM,
    input  readdataM, memstallM, misalignM
  );

  modport slave (
    input  memreadM, memwriteM, aluoutM, writedataM,
    output readdataM, memstallM, misalignM
  );

endinterface

// File: rtl/sram_1rw.sv
// Single-port word array: synchronous write, asynchronous read on the same index.
module sram_1rw
  import mips_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // storage write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: latches a request, stalls the
// pipeline for 1+WAIT_STATES cycles, then commits the write / returns load data.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic              req_s;
  logic              aligned_s;
  logic [IDX_W-1:0]  in_idx_s;
  logic              stall_s;
  logic              misalign_s;
  logic              commit_rd_s;
  logic              commit_wr_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              addr_unused_s;

  assign req_s         = bus.memreadM | bus.memwriteM;
  assign aligned_s     = is_aligned(bus.aluoutM);
  assign in_idx_s      = bus.aluoutM[IDX_W+1:2];
  // upper address bits alias; they take no part in the access
  assign addr_unused_s = ^bus.aluoutM[ADDR_W-1:IDX_W+2];

  // next-state, request latch and commit decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    stall_s     = 1'b0;
    misalign_s  = 1'b0;
    commit_rd_s = 1'b0;
    commit_wr_s = 1'b0;
    mem_idx_s   = idx_q;
    mem_wdata_s = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_s && aligned_s) begin
          stall_s     = 1'b1;
          rd_d        = bus.memreadM;
          wr_d        = bus.memwriteM;
          idx_d       = in_idx_s;
          wdata_d     = bus.writedataM;
          cnt_d       = WAIT_LD;
          mem_idx_s   = in_idx_s;
          mem_wdata_s = bus.writedataM;
          // with no wait states the commit edge is the request edge itself
          if (WAIT_STATES == 0) begin
            state_d     = DONE;
            commit_rd_s = bus.memreadM;
            commit_wr_s = bus.memwriteM;
          end else begin
            state_d     = BUSY;
          end
        end else if (req_s) begin
          misalign_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d     = DONE;
          commit_rd_s = rd_q;
          commit_wr_s = wr_q;
        end else begin
          state_d     = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // read data sampled before the write lands, so read+write returns old contents
    if (commit_rd_s) begin
      readdata_d = mem_rdata_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // state, counter, request latch and load-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
    end
  end

  sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .we    (commit_wr_s & ~reset),
    .addr  (mem_idx_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  assign bus.readdataM = readdata_q;
  assign bus.memstallM = stall_s & ~reset;
  assign bus.misalignM = misalign_s & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states and one with none.
module tb_dmem_responder;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  logic        mr [2];
  logic        mw [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        stall_w [2];
  logic        mis_w   [2];
  logic [31:0] rdat_w  [2];

  assign bus_a.memreadM   = mr[0];
  assign bus_a.memwriteM  = mw[0];
  assign bus_a.aluoutM    = ad[0];
  assign bus_a.writedataM = wd[0];
  assign bus_b.memreadM   = mr[1];
  assign bus_b.memwriteM  = mw[1];
  assign bus_b.aluoutM    = ad[1];
  assign bus_b.writedataM = wd[1];
  assign stall_w[0] = bus_a.memstallM;
  assign stall_w[1] = bus_b.memstallM;
  assign mis_w[0]   = bus_a.misalignM;
  assign mis_w[1]   = bus_b.misalignM;
  assign rdat_w[0]  = bus_a.readdataM;
  assign rdat_w[1]  = bus_b.readdataM;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on DUT d; returns stall cycles, misalign at request, and readdata at exit.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wdat,
                        output int stalls, output logic mis, output logic [31:0] rdata);
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = wdat;
    stalls = 0;
    @(negedge clk);
    mis = mis_w[d];
    while (stall_w[d] && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      mr[d] = 1'b0; mw[d] = 1'b0;
      @(negedge clk);
    end
    rdata = rdat_w[d];
    mr[d] = 1'b0; mw[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  int          st;
  logic        mi;
  logic [31:0] rv;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'h0; wd[i] = 32'h0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_value("rst_stall_a", {31'd0, stall_w[0]}, 32'd0);
    check_value("rst_mis_a", {31'd0, mis_w[0]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_rdata_a", rdat_w[0], 32'h0);
    check_value("rst_rdata_b", rdat_w[1], 32'h0);
    check_value("rst_stall_b", {31'd0, stall_w[1]}, 32'd0);
    @(posedge clk); #1;

    // 1: write with two wait states
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, mi, rv);
    check_value("t1_stalls", 32'(st), 32'd3);
    check_value("t1_rdata_hold", rv, 32'h0);
    // 2: read back
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, st, mi, rv);
    check_value("t2_stalls", 32'(st), 32'd3);
    check_value("t2_rdata", rv, 32'hDEADBEEF);
    @(negedge clk);
    check_value("t2_rdata_held", rdat_w[0], 32'hDEADBEEF);
    @(posedge clk); #1;
    // 3: misaligned read
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, st, mi, rv);
    check_value("t3_mis", {31'd0, mi}, 32'd1);
    check_value("t3_stalls", 32'(st), 32'd0);
    check_value("t3_rdata", rv, 32'hDEADBEEF);
    @(negedge clk);
    check_value("t3_mis_drop", {31'd0, mis_w[0]}, 32'd0);
    check_value("t3_rdata_after", rdat_w[0], 32'hDEADBEEF);
    @(posedge clk); #1;

    // 4: zero wait states, back-to-back
    access(1, 1'b0, 1'b1, 32'h0, 32'h11111111, st, mi, rv);
    check_value("t4_w0_stalls", 32'(st), 32'd1);
    access(1, 1'b0, 1'b1, 32'h4, 32'h22222222, st, mi, rv);
    check_value("t4_w1_stalls", 32'(st), 32'd1);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, st, mi, rv);
    check_value("t4_r0_stalls", 32'(st), 32'd1);
    check_value("t4_r0_data", rv, 32'h11111111);
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, st, mi, rv);
    check_value("t4_r1_stalls", 32'(st), 32'd1);
    check_value("t4_r1_data", rv, 32'h22222222);

    // 5: read+write together returns the old word
    access(1, 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, st, mi, rv);
    check_value("t5_write_hold", rv, 32'h22222222);
    access(1, 1'b1, 1'b1, 32'h10, 32'h0, st, mi, rv);
    check_value("t5_rw_stalls", 32'(st), 32'd1);
    check_value("t5_rw_data", rv, 32'hA5A5A5A5);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, st, mi, rv);
    check_value("t5_read_new", rv, 32'h0);

    // 6: reset while BUSY drops the pending write
    access(0, 1'b0, 1'b1, 32'h8, 32'h12345678, st, mi, rv);
    mw[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'h0000CAFE;
    @(negedge clk);
    check_value("t6_req_stall", {31'd0, stall_w[0]}, 32'd1);
    @(posedge clk); #1;
    mw[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_value("t6_rst_stall", {31'd0, stall_w[0]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_value("t6_idle_stall", {31'd0, stall_w[0]}, 32'd0);
    check_value("t6_rst_rdata", rdat_w[0], 32'h0);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h108, 32'h0, st, mi, rv);
    check_value("t6_alias_stalls", 32'(st), 32'd3);
    check_value("t6_word2", rv, 32'h12345678);

    // reset coinciding with the commit edge also drops the write
    mw[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'h0000BEEF;
    @(posedge clk); #1;
    mw[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_value("t6b_stall", {31'd0, stall_w[0]}, 32'd0);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, st, mi, rv);
    check_value("t6b_word2", rv, 32'h12345678);

    // write through an alias, read through the base address
    access(0, 1'b0, 1'b1, 32'h108, 32'h0F0F0F0F, st, mi, rv);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, st, mi, rv);
    check_value("t6c_alias_write", rv, 32'h0F0F0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
